// File: rtl/scene_ctrl.sv
// Game-flow controller: sequences MENU -> BATTLE -> ENDGAME -> MENU and
// drives the scene-mux select, switching only on vsync rising edges.
module scene_ctrl #(
  parameter int ENDGAME_FRAMES = 300,
  parameter int CNT_W          = 16
) (
  input  logic       i_pclk,
  input  logic       i_rst,
  input  logic       i_vs,
  input  logic       i_start,
  input  logic       i_game_over,
  input  logic       i_player_won,
  output logic [1:0] o_sel,
  output logic       o_scene_change,
  output logic       o_battle_start,
  output logic       o_winner
);

  typedef enum logic [1:0] {
    S_MENU    = 2'b00,
    S_BATTLE  = 2'b01,
    S_ENDGAME = 2'b10,
    S_ILLEGAL = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ENDGAME_FRAMES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ENDGAME_FRAMES - 1);

  state_t           state_q, state_nxt, scene_nxt;
  logic             pending_q, pending_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             winner_nxt, chg_nxt, bs_nxt;
  logic             vs_d, start_d;
  logic             frame_tick, start_edge, set_cond;

  assign frame_tick = i_vs & ~vs_d;
  assign start_edge = i_start & ~start_d;

  // The state register is the scene select itself, so o_sel doubles as the
  // observable FSM state.
  assign o_sel = state_q;

  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= S_MENU;
      pending_q      <= 1'b0;
      cnt_q          <= '0;
      o_winner       <= 1'b0;
      o_scene_change <= 1'b0;
      o_battle_start <= 1'b0;
      vs_d           <= 1'b0;
      start_d        <= 1'b0;
    end else begin
      state_q        <= state_nxt;
      pending_q      <= pending_nxt;
      cnt_q          <= cnt_nxt;
      o_winner       <= winner_nxt;
      o_scene_change <= chg_nxt;
      o_battle_start <= bs_nxt;
      vs_d           <= i_vs;
      start_d        <= i_start;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    scene_nxt   = S_MENU;
    pending_nxt = pending_q;
    cnt_nxt     = cnt_q;
    winner_nxt  = o_winner;
    chg_nxt     = 1'b0;
    bs_nxt      = 1'b0;
    set_cond    = 1'b0;

    case (state_q)
      S_MENU: begin
        set_cond  = start_edge;
        scene_nxt = S_BATTLE;
        cnt_nxt   = '0;
      end
      S_BATTLE: begin
        set_cond  = i_game_over;
        scene_nxt = S_ENDGAME;
        cnt_nxt   = '0;
        // Only the first game-over sample of a battle decides the winner.
        if (i_game_over && !pending_q) winner_nxt = i_player_won;
      end
      S_ENDGAME: begin
        // Timeout is judged on the tick that would bring the count to the limit.
        set_cond  = start_edge | (frame_tick & (cnt_q >= CNT_LAST));
        scene_nxt = S_MENU;
        if (frame_tick && (cnt_q < CNT_MAX)) cnt_nxt = cnt_q + CNT_W'(1);
      end
      default: begin
        set_cond  = 1'b0;
        scene_nxt = S_MENU;
      end
    endcase

    if (state_q == S_ILLEGAL) begin
      state_nxt   = S_MENU;
      chg_nxt     = 1'b1;
      pending_nxt = 1'b0;
    end else if ((pending_q | set_cond) & frame_tick) begin
      state_nxt   = scene_nxt;
      chg_nxt     = 1'b1;
      pending_nxt = 1'b0;
      if (scene_nxt == S_BATTLE) begin
        bs_nxt     = 1'b1;
        winner_nxt = 1'b0;
      end
    end else if (set_cond) begin
      pending_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_scene_ctrl.sv
// Directed bench for scene_ctrl with ENDGAME_FRAMES = 3 and 100-cycle frames.
module tb_scene_ctrl;

  logic       i_pclk, i_rst, i_vs, i_start, i_game_over, i_player_won;
  logic [1:0] o_sel;
  logic       o_scene_change, o_battle_start, o_winner;

  int         vectors = 0;
  int         miscompares = 0;
  logic [1:0] obs_sel;
  logic       obs_chg, obs_bs, obs_win;
  int         chg_cnt, bs_cnt;
  bit         start_hold;

  scene_ctrl #(.ENDGAME_FRAMES(3), .CNT_W(16)) dut (
    .i_pclk        (i_pclk),
    .i_rst         (i_rst),
    .i_vs          (i_vs),
    .i_start       (i_start),
    .i_game_over   (i_game_over),
    .i_player_won  (i_player_won),
    .o_sel         (o_sel),
    .o_scene_change(o_scene_change),
    .o_battle_start(o_battle_start),
    .o_winner      (o_winner)
  );

  initial i_pclk = 1'b0;
  always #5 i_pclk = ~i_pclk;

  task automatic step();
    @(posedge i_pclk);
    #1;
  endtask

  // One 100-cycle frame: vsync high for cycles 0..2, optional 3-cycle start
  // pulse at start_at. Outputs right after the tick edge are captured.
  task automatic run_frame(input int start_at);
    chg_cnt = 0;
    bs_cnt  = 0;
    for (int c = 0; c < 100; c++) begin
      i_vs    = (c < 3);
      i_start = start_hold | (start_at >= 0 && c >= start_at && c < start_at + 3);
      step();
      if (o_scene_change) chg_cnt++;
      if (o_battle_start) bs_cnt++;
      if (c == 0) begin
        obs_sel = o_sel;
        obs_chg = o_scene_change;
        obs_bs  = o_battle_start;
        obs_win = o_winner;
      end
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    repeat (3) step();
    i_rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_vs = 0; i_start = 0; i_game_over = 0; i_player_won = 0;
    start_hold = 0;
    repeat (3) step();
    vectors++; if (o_sel !== 2'b00) begin miscompares++; $display("FAIL reset_sel: got %b want 00", o_sel); end
    vectors++; if (o_scene_change !== 1'b0) begin miscompares++; $display("FAIL reset_chg: got %b want 0", o_scene_change); end
    vectors++; if (o_battle_start !== 1'b0) begin miscompares++; $display("FAIL reset_bs: got %b want 0", o_battle_start); end
    vectors++; if (o_winner !== 1'b0) begin miscompares++; $display("FAIL reset_win: got %b want 0", o_winner); end
    i_rst = 1'b0;
    step();
  endtask

  task automatic test_idle();
    for (int f = 0; f < 3; f++) begin
      run_frame(-1);
      vectors++; if (obs_sel !== 2'b00) begin miscompares++; $display("FAIL idle_sel[%0d]: got %b want 00", f, obs_sel); end
      vectors++; if (chg_cnt !== 0) begin miscompares++; $display("FAIL idle_chg[%0d]: got %0d pulses want 0", f, chg_cnt); end
      vectors++; if (bs_cnt !== 0) begin miscompares++; $display("FAIL idle_bs[%0d]: got %0d pulses want 0", f, bs_cnt); end
    end
  endtask

  task automatic test_menu_start();
    run_frame(30);
    vectors++; if (chg_cnt !== 0) begin miscompares++; $display("FAIL menu_midframe_chg: got %0d want 0", chg_cnt); end
    vectors++; if (o_sel !== 2'b00) begin miscompares++; $display("FAIL menu_midframe_sel: got %b want 00", o_sel); end
    run_frame(-1);
    vectors++; if (obs_sel !== 2'b01) begin miscompares++; $display("FAIL menu_sel: got %b want 01", obs_sel); end
    vectors++; if (obs_chg !== 1'b1) begin miscompares++; $display("FAIL menu_chg: got %b want 1", obs_chg); end
    vectors++; if (obs_bs !== 1'b1) begin miscompares++; $display("FAIL menu_bs: got %b want 1", obs_bs); end
    vectors++; if (chg_cnt !== 1) begin miscompares++; $display("FAIL menu_chg_width: got %0d want 1", chg_cnt); end
    vectors++; if (bs_cnt !== 1) begin miscompares++; $display("FAIL menu_bs_width: got %0d want 1", bs_cnt); end
  endtask

  task automatic test_battle_ignores_start();
    run_frame(30);
    run_frame(-1);
    vectors++; if (obs_sel !== 2'b01) begin miscompares++; $display("FAIL battle_start_sel: got %b want 01", obs_sel); end
    vectors++; if (chg_cnt !== 0) begin miscompares++; $display("FAIL battle_start_chg: got %0d want 0", chg_cnt); end
  endtask

  task automatic test_game_over();
    repeat (10) step();
    i_game_over = 1'b1; i_player_won = 1'b1;
    step();
    vectors++; if (o_winner !== 1'b1) begin miscompares++; $display("FAIL winner_load: got %b want 1", o_winner); end
    repeat (5) step();
    i_player_won = 1'b0;
    repeat (5) step();
    vectors++; if (o_winner !== 1'b1) begin miscompares++; $display("FAIL winner_hold: got %b want 1", o_winner); end
    vectors++; if (o_sel !== 2'b01) begin miscompares++; $display("FAIL gameover_wait_sel: got %b want 01", o_sel); end
    run_frame(-1);
    vectors++; if (obs_sel !== 2'b10) begin miscompares++; $display("FAIL gameover_sel: got %b want 10", obs_sel); end
    vectors++; if (obs_chg !== 1'b1) begin miscompares++; $display("FAIL gameover_chg: got %b want 1", obs_chg); end
    vectors++; if (obs_bs !== 1'b0) begin miscompares++; $display("FAIL gameover_bs: got %b want 0", obs_bs); end
    vectors++; if (obs_win !== 1'b1) begin miscompares++; $display("FAIL gameover_win: got %b want 1", obs_win); end
  endtask

  task automatic test_endgame_timeout();
    for (int f = 0; f < 2; f++) begin
      run_frame(-1);
      vectors++; if (obs_sel !== 2'b10) begin miscompares++; $display("FAIL endgame_stay_sel[%0d]: got %b want 10", f, obs_sel); end
      vectors++; if (chg_cnt !== 0) begin miscompares++; $display("FAIL endgame_stay_chg[%0d]: got %0d want 0", f, chg_cnt); end
    end
    i_game_over = 1'b0;
    run_frame(-1);
    vectors++; if (obs_sel !== 2'b00) begin miscompares++; $display("FAIL timeout_sel: got %b want 00", obs_sel); end
    vectors++; if (obs_chg !== 1'b1) begin miscompares++; $display("FAIL timeout_chg: got %b want 1", obs_chg); end
    vectors++; if (obs_bs !== 1'b0) begin miscompares++; $display("FAIL timeout_bs: got %b want 0", obs_bs); end
    vectors++; if (obs_win !== 1'b1) begin miscompares++; $display("FAIL timeout_win: got %b want 1", obs_win); end
    run_frame(30);
    run_frame(-1);
    vectors++; if (obs_sel !== 2'b01) begin miscompares++; $display("FAIL rebattle_sel: got %b want 01", obs_sel); end
    vectors++; if (obs_bs !== 1'b1) begin miscompares++; $display("FAIL rebattle_bs: got %b want 1", obs_bs); end
    vectors++; if (obs_win !== 1'b0) begin miscompares++; $display("FAIL rebattle_win: got %b want 0", obs_win); end
  endtask

  task automatic test_start_held();
    do_reset();
    run_frame(-1);
    start_hold = 1'b1;
    run_frame(-1);
    vectors++; if (obs_sel !== 2'b01) begin miscompares++; $display("FAIL held_simul_sel: got %b want 01", obs_sel); end
    vectors++; if (obs_chg !== 1'b1) begin miscompares++; $display("FAIL held_simul_chg: got %b want 1", obs_chg); end
    run_frame(-1);
    vectors++; if (obs_sel !== 2'b01) begin miscompares++; $display("FAIL held_battle_sel: got %b want 01", obs_sel); end
    vectors++; if (chg_cnt !== 0) begin miscompares++; $display("FAIL held_battle_chg: got %0d want 0", chg_cnt); end
    i_game_over = 1'b1; i_player_won = 1'b0;
    run_frame(-1);
    vectors++; if (obs_sel !== 2'b10) begin miscompares++; $display("FAIL held_endgame_sel: got %b want 10", obs_sel); end
    vectors++; if (obs_win !== 1'b0) begin miscompares++; $display("FAIL held_endgame_win: got %b want 0", obs_win); end
    i_game_over = 1'b0;
    for (int f = 0; f < 2; f++) begin
      run_frame(-1);
      vectors++; if (obs_sel !== 2'b10) begin miscompares++; $display("FAIL held_no_exit_sel[%0d]: got %b want 10", f, obs_sel); end
    end
    run_frame(-1);
    vectors++; if (obs_sel !== 2'b00) begin miscompares++; $display("FAIL held_timeout_sel: got %b want 00", obs_sel); end
    run_frame(-1);
    vectors++; if (obs_sel !== 2'b00) begin miscompares++; $display("FAIL held_no_chain_sel: got %b want 00", obs_sel); end
    vectors++; if (chg_cnt !== 0) begin miscompares++; $display("FAIL held_no_chain_chg: got %0d want 0", chg_cnt); end
    start_hold = 1'b0;
    run_frame(-1);
  endtask

  task automatic test_endgame_start_exit();
    run_frame(30);
    run_frame(-1);
    vectors++; if (obs_sel !== 2'b01) begin miscompares++; $display("FAIL early_battle_sel: got %b want 01", obs_sel); end
    i_game_over = 1'b1; i_player_won = 1'b1;
    run_frame(-1);
    vectors++; if (obs_sel !== 2'b10) begin miscompares++; $display("FAIL early_endgame_sel: got %b want 10", obs_sel); end
    vectors++; if (obs_win !== 1'b1) begin miscompares++; $display("FAIL early_endgame_win: got %b want 1", obs_win); end
    i_game_over = 1'b0;
    run_frame(30);
    vectors++; if (chg_cnt !== 0) begin miscompares++; $display("FAIL early_press_chg: got %0d want 0", chg_cnt); end
    run_frame(-1);
    vectors++; if (obs_sel !== 2'b00) begin miscompares++; $display("FAIL early_exit_sel: got %b want 00", obs_sel); end
    vectors++; if (obs_chg !== 1'b1) begin miscompares++; $display("FAIL early_exit_chg: got %b want 1", obs_chg); end
  endtask

  task automatic test_reset_mid();
    run_frame(30);
    run_frame(-1);
    i_game_over = 1'b1;
    run_frame(-1);
    i_game_over = 1'b0;
    vectors++; if (o_sel !== 2'b10) begin miscompares++; $display("FAIL rstmid_pre_sel: got %b want 10", o_sel); end
    repeat (20) step();
    i_start = 1'b1; step(); step();
    i_start = 1'b0; step();
    #2 i_rst = 1'b1;
    #1;
    vectors++; if (o_sel !== 2'b00) begin miscompares++; $display("FAIL rstmid_async_sel: got %b want 00", o_sel); end
    repeat (3) step();
    i_rst = 1'b0;
    step();
    run_frame(-1);
    vectors++; if (obs_sel !== 2'b00) begin miscompares++; $display("FAIL rstmid_after_sel: got %b want 00", obs_sel); end
    vectors++; if (chg_cnt !== 0) begin miscompares++; $display("FAIL rstmid_after_chg: got %0d want 0", chg_cnt); end
    repeat (20) step();
    i_start = 1'b1; step(); step();
    i_start = 1'b0; step();
    i_rst = 1'b1;
    repeat (3) step();
    i_rst = 1'b0;
    step();
    run_frame(-1);
    vectors++; if (obs_sel !== 2'b00) begin miscompares++; $display("FAIL rstmenu_sel: got %b want 00", obs_sel); end
    vectors++; if (bs_cnt !== 0) begin miscompares++; $display("FAIL rstmenu_bs: got %0d want 0", bs_cnt); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_menu_start();
    test_battle_ignores_start();
    test_game_over();
    test_endgame_timeout();
    test_start_held();
    test_endgame_start_exit();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
